ternary_systolic_tile: RTL and testbench

Output-stationary ROWS x COLS systolic tile computing Y[i][j] = sum over k of W[k][i]*X[k][j], with ternary weights and signed activations.
- Generalises the free-running ternary array: internal input skewing, per-beat valid tagging, tile-length counting, optional saturating accumulation, and a row-serial valid/ready result drain.
- Sits between the activation/weight streamers and the output/normalisation stage of the matmul-free datapath.

---
 rtl/ternary_pkg.sv | 36 +++
 rtl/ternary_pe.sv | 70 +++++++
 rtl/ternary_systolic_tile.sv | 216 +++++++++++++++++++++
 tb/tb_ternary_systolic_tile.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared encodings, FSM states and the ternary select/negate decode for the
// ternary systolic tile.
package ternary_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;
  localparam logic [1:0] W_RSV  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } tile_state_t;

  typedef struct packed {
    logic sel;  // pass the activation through
    logic neg;  // negate it
  } tern_op_t;

  // The reserved code behaves exactly like zero.
  function automatic tern_op_t ternary_decode(input logic [1:0] w);
    tern_op_t op;
    op.sel = 1'b0;
    op.neg = 1'b0;
    case (w)
      W_POS:          op.sel = 1'b1;
      W_NEG:          begin op.sel = 1'b1; op.neg = 1'b1; end
      W_ZERO, W_RSV:  op.sel = 1'b0;
      default:        op.sel = 1'b0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ternary_pe.sv
// One processing element: registered x/w/tag pass-through plus a ternary
// accumulator with optional saturation.
module ternary_pe
  import ternary_pkg::*;
#(
  parameter int XW   = 16,
  parameter int ACCW = 32
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            sat_en_i,
  input  logic            v_i,
  input  logic [XW-1:0]   x_i,
  input  logic [1:0]      w_i,
  output logic [XW-1:0]   x_o,
  output logic [1:0]      w_o,
  output logic            v_o,
  output logic [ACCW-1:0] acc_o
);

  localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  tern_op_t        op;
  logic [ACCW:0]   x_ext;
  logic [ACCW:0]   prod;
  logic [ACCW:0]   sum;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_d;

  // One guard bit keeps -(-2^(XW-1)) and every acc+prod exact, so overflow
  // is simply the top two sum bits disagreeing.
  always_comb begin
    op    = ternary_decode(w_i);
    x_ext = {{(ACCW+1-XW){x_i[XW-1]}}, x_i};
    prod  = '0;
    if (op.sel) begin
      prod = op.neg ? -x_ext : x_ext;
    end
    sum   = {acc_q[ACCW-1], acc_q} + prod;
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (v_i) begin
      if (sat_en_i && (sum[ACCW] != sum[ACCW-1])) begin
        acc_d = sum[ACCW] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum[ACCW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      x_o   <= '0;
      w_o   <= '0;
      v_o   <= 1'b0;
      acc_q <= '0;
    end else begin
      x_o   <= x_i;
      w_o   <= w_i;
      v_o   <= v_i;
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ternary_systolic_tile.sv
// Output-stationary ROWS x COLS ternary systolic tile: skewed input streaming,
// tile-length control, flush and a row-serial valid/ready result drain.
module ternary_systolic_tile
  import ternary_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int XW   = 16,
  parameter int ACCW = 32,
  parameter int KW   = 8,
  localparam int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 sat_en,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [COLS*XW-1:0]   x_data,
  input  logic [ROWS*2-1:0]    w_data,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [COLS*ACCW-1:0] y_row,
  output logic [IDXW-1:0]      y_row_idx,
  output logic                 y_last,
  output logic                 busy
);

  localparam int FL_LEN = ROWS + COLS - 1;
  localparam int FLW    = $clog2(ROWS + COLS);

  tile_state_t     state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic [FLW-1:0]  flush_q, flush_d;
  logic [IDXW-1:0] row_q, row_d;
  logic            sat_q, sat_d;
  logic            clr;
  logic            inj_v;
  logic            last_row;

  assign last_row = (row_q == IDXW'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    sat_d   = sat_q;
    clr     = 1'b0;
    x_ready = 1'b0;
    y_valid = 1'b0;
    y_last  = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          k_len_d = k_len;
          sat_d   = sat_en;
          beat_d  = '0;
          row_d   = '0;
          state_d = (k_len == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        x_ready = 1'b1;
        if (x_valid) begin
          beat_d = beat_q + KW'(1);
          if (beat_q + KW'(1) == k_len_q) begin
            flush_d = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flush_q == FLW'(FL_LEN - 1)) begin
          row_d   = '0;
          state_d = DRAIN;
        end else begin
          flush_d = flush_q + FLW'(1);
        end
      end
      DRAIN: begin
        y_valid = 1'b1;
        y_last  = last_row;
        if (y_ready) begin
          if (last_row) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + IDXW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      sat_q   <= sat_d;
    end
  end

  assign inj_v = x_valid & x_ready;

  logic [XW-1:0] x_top  [COLS];
  logic [1:0]    w_left [ROWS];
  logic          v_left [ROWS];

  // Column j activations enter j cycles late so they meet their weight.
  genvar gi, gj;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_xskew
      if (gi == 0) begin : g_direct
        assign x_top[gi] = x_data[XW-1:0];
      end else begin : g_delay
        logic [XW-1:0] dly_q [gi];
        always_ff @(posedge clock) begin
          if (rst) begin
            for (int k = 0; k < gi; k++) dly_q[k] <= '0;
          end else begin
            dly_q[0] <= x_data[gi*XW +: XW];
            for (int k = 1; k < gi; k++) dly_q[k] <= dly_q[k-1];
          end
        end
        assign x_top[gi] = dly_q[gi-1];
      end
    end

    // The valid tag rides alongside the weight lane of each row.
    for (gi = 0; gi < ROWS; gi++) begin : g_wskew
      if (gi == 0) begin : g_direct
        assign w_left[gi] = w_data[1:0];
        assign v_left[gi] = inj_v;
      end else begin : g_delay
        logic [2:0] dly_q [gi];
        always_ff @(posedge clock) begin
          if (rst) begin
            for (int k = 0; k < gi; k++) dly_q[k] <= '0;
          end else begin
            dly_q[0] <= {inj_v, w_data[gi*2 +: 2]};
            for (int k = 1; k < gi; k++) dly_q[k] <= dly_q[k-1];
          end
        end
        assign w_left[gi] = dly_q[gi-1][1:0];
        assign v_left[gi] = dly_q[gi-1][2];
      end
    end
  endgenerate

  logic [XW-1:0]   x_pe   [ROWS][COLS];
  logic [1:0]      w_pe   [ROWS][COLS];
  logic            v_pe   [ROWS][COLS];
  logic [ACCW-1:0] acc_pe [ROWS][COLS];

  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_col
        logic [XW-1:0] x_in;
        logic [1:0]    w_in;
        logic          v_in;
        if (gi == 0) begin : g_xt
          assign x_in = x_top[gj];
        end else begin : g_xn
          assign x_in = x_pe[gi-1][gj];
        end
        if (gj == 0) begin : g_wl
          assign w_in = w_left[gi];
          assign v_in = v_left[gi];
        end else begin : g_wn
          assign w_in = w_pe[gi][gj-1];
          assign v_in = v_pe[gi][gj-1];
        end
        ternary_pe #(
          .XW   (XW),
          .ACCW (ACCW)
        ) u_pe (
          .clock    (clock),
          .rst      (rst),
          .clr_i    (clr),
          .sat_en_i (sat_q),
          .v_i      (v_in),
          .x_i      (x_in),
          .w_i      (w_in),
          .x_o      (x_pe[gi][gj]),
          .w_o      (w_pe[gi][gj]),
          .v_o      (v_pe[gi][gj]),
          .acc_o    (acc_pe[gi][gj])
        );
      end
    end

    for (gj = 0; gj < COLS; gj++) begin : g_yrow
      assign y_row[gj*ACCW +: ACCW] = (state_q == DRAIN) ? acc_pe[row_q][gj] : '0;
    end
  endgenerate

  assign y_row_idx = row_q;

endmodule

// File: tb/tb_ternary_systolic_tile.sv
// Randomized and directed bench for ternary_systolic_tile; two instances
// (32-bit and 16-bit accumulators) share stimulus and a behavioural model.
module tb_ternary_systolic_tile;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int XW   = 16;
  localparam int KW   = 8;
  localparam int XB   = COLS * XW;
  localparam int WB   = ROWS * 2;

  logic          clock = 1'b0;
  logic          rst, start, sat_en, x_valid, y_ready;
  logic [KW-1:0] k_len;
  logic [XB-1:0] x_data;
  logic [WB-1:0] w_data;

  logic          x_ready_a, y_valid_a, y_last_a, busy_a;
  logic [127:0]  y_row_a;
  logic [1:0]    idx_a;
  logic          x_ready_b, y_valid_b, y_last_b, busy_b;
  logic [63:0]   y_row_b;
  logic [1:0]    idx_b;

  ternary_systolic_tile #(.ROWS(ROWS), .COLS(COLS), .XW(XW), .ACCW(32), .KW(KW)) dut_a (
    .clock(clock), .rst(rst), .start(start), .k_len(k_len), .sat_en(sat_en),
    .x_valid(x_valid), .x_ready(x_ready_a), .x_data(x_data), .w_data(w_data),
    .y_valid(y_valid_a), .y_ready(y_ready), .y_row(y_row_a), .y_row_idx(idx_a),
    .y_last(y_last_a), .busy(busy_a)
  );

  ternary_systolic_tile #(.ROWS(ROWS), .COLS(COLS), .XW(XW), .ACCW(16), .KW(KW)) dut_b (
    .clock(clock), .rst(rst), .start(start), .k_len(k_len), .sat_en(sat_en),
    .x_valid(x_valid), .x_ready(x_ready_b), .x_data(x_data), .w_data(w_data),
    .y_valid(y_valid_b), .y_ready(y_ready), .y_row(y_row_b), .y_row_idx(idx_b),
    .y_last(y_last_b), .busy(busy_b)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XB-1:0] bx [64];
  logic [WB-1:0] bw [64];
  bit            vpat [$];
  longint        ex_a [ROWS][COLS];
  longint        ex_b [ROWS][COLS];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint step(input longint acc, input longint p, input int a, input bit sat);
    longint s, mx, mn, md;
    md = longint'(1) <<< a;
    mx = (longint'(1) <<< (a - 1)) - 1;
    mn = -(longint'(1) <<< (a - 1));
    s  = acc + p;
    if (sat) begin
      if (s > mx) s = mx;
      if (s < mn) s = mn;
    end else begin
      s = s & (md - 1);
      if (s > mx) s = s - md;
    end
    return s;
  endfunction

  function automatic longint wval(input logic [1:0] w);
    if (w == 2'b01) return 1;
    if (w == 2'b11) return -1;
    return 0;
  endfunction

  task automatic fill_const(input int k, input logic [XB-1:0] xv, input logic [WB-1:0] wv);
    for (int i = 0; i < k; i++) begin
      bx[i] = xv;
      bw[i] = wv;
    end
  endtask

  task automatic fill_rand(input int k);
    for (int i = 0; i < k; i++) begin
      bx[i] = {$urandom, $urandom};
      bw[i] = WB'($urandom);
    end
  endtask

  // vmode: 0 always valid, 1 use vpat then valid, 2 random valid
  task automatic run_tile(input string name, input int klen, input bit sat, input int vmode,
                          input int hold0, input bit start_in_drain);
    int n, cyc, acc_cnt, last_acc, exp_first, hold;
    bit acc_now;
    logic [XB-1:0] qx [$];
    logic [WB-1:0] qw [$];
    logic [127:0]  er_a, er_b;
    longint pa, pb, p;
    start  = 1'b1;
    k_len  = KW'(klen);
    sat_en = sat;
    @(posedge clock); #1;
    start    = 1'b0;
    k_len    = KW'($urandom);
    sat_en   = ~sat;
    n        = 1;
    cyc      = 0;
    acc_cnt  = 0;
    last_acc = 1;
    while (y_valid_a !== 1'b1 && n < 3000) begin
      check({name, " x_ready"}, 128'(x_ready_a), 128'(acc_cnt < klen));
      case (vmode)
        0:       x_valid = 1'b1;
        1:       x_valid = (cyc < vpat.size()) ? vpat[cyc] : 1'b1;
        default: x_valid = 1'($urandom_range(0, 1));
      endcase
      if (acc_cnt < klen) begin
        x_data = bx[acc_cnt];
        w_data = bw[acc_cnt];
      end else begin
        x_data = {$urandom, $urandom};
        w_data = WB'($urandom);
      end
      acc_now = x_valid && x_ready_a;
      @(posedge clock); #1;
      n++;
      cyc++;
      if (acc_now) begin
        qx.push_back(x_data);
        qw.push_back(w_data);
        acc_cnt++;
        last_acc = n;
      end
    end
    x_valid   = 1'b0;
    exp_first = (klen == 0) ? 1 : last_acc + ROWS + COLS - 1;
    check({name, " y_valid_reached"}, 128'(y_valid_a), 128'(1));
    check({name, " latency"}, 128'(n), 128'(exp_first));
    check({name, " beats"}, 128'(acc_cnt), 128'(klen));

    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        pa = 0;
        pb = 0;
        for (int k = 0; k < qx.size(); k++) begin
          p  = wval(qw[k][i*2 +: 2]) * longint'($signed(qx[k][j*XW +: XW]));
          pa = step(pa, p, 32, sat);
          pb = step(pb, p, 16, sat);
        end
        ex_a[i][j] = pa;
        ex_b[i][j] = pb;
      end
    end

    for (int r = 0; r < ROWS; r++) begin
      hold = (r == 0) ? hold0 : $urandom_range(0, 2);
      er_a = '0;
      er_b = '0;
      for (int j = 0; j < COLS; j++) begin
        pa = ex_a[r][j];
        pb = ex_b[r][j];
        er_a[j*32 +: 32] = pa[31:0];
        er_b[j*16 +: 16] = pb[15:0];
      end
      for (int h = 0; h <= hold; h++) begin
        y_ready = (h == hold);
        check({name, " y_valid"}, 128'(y_valid_a), 128'(1));
        check({name, " y_row_idx"}, 128'(idx_a), 128'(r));
        check({name, " y_last"}, 128'(y_last_a), 128'(r == ROWS - 1));
        check({name, " busy_drain"}, 128'(busy_a), 128'(1));
        check({name, " y_row_acc32"}, y_row_a, er_a);
        check({name, " y_row_acc16"}, 128'(y_row_b), er_b);
        check({name, " y_valid_acc16"}, 128'(y_valid_b), 128'(1));
        if (start_in_drain && r == 1 && h == 0) begin
          start = 1'b1;
          k_len = KW'(1);
        end
        @(posedge clock); #1;
        start = 1'b0;
      end
    end
    y_ready = 1'b0;
    check({name, " y_valid_after"}, 128'(y_valid_a), 128'(0));
    check({name, " busy_after"}, 128'(busy_a), 128'(0));
    check({name, " idx_after"}, 128'(idx_a), 128'(0));
    check({name, " busy_after_acc16"}, 128'(busy_b), 128'(0));
    @(posedge clock); #1;
    check({name, " idle_hold"}, 128'({busy_a, y_valid_a, x_ready_a}), 128'(0));
    $display("tile %s k_len=%0d sat=%0d beats=%0d first_y_valid=%0d", name, klen, sat, acc_cnt, n);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    k_len   = '0;
    sat_en  = 1'b0;
    x_valid = 1'b0;
    x_data  = '0;
    w_data  = '0;
    y_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset x_ready", 128'(x_ready_a), 128'(0));
    check("reset y_valid", 128'(y_valid_a), 128'(0));
    check("reset y_row", y_row_a, 128'(0));
    check("reset idx", 128'(idx_a), 128'(0));
    check("reset y_last", 128'(y_last_a), 128'(0));
    check("reset busy", 128'(busy_a), 128'(0));
    rst = 1'b0;
    @(posedge clock); #1;

    // 1: single beat, mixed weights
    fill_const(1, {16'd4, 16'd3, 16'd2, 16'd1}, {2'b01, 2'b00, 2'b11, 2'b01});
    run_tile("t1_single", 1, 1'b0, 0, 0, 1'b0);

    // 2: bubbles in the beat stream
    vpat = '{1, 0, 1, 0, 1, 1};
    fill_const(4, {4{16'd5}}, {4{2'b01}});
    run_tile("t2_bubbles", 4, 1'b0, 1, 0, 1'b0);

    // 3: saturation / wrap at the accumulator limits
    fill_const(2, {4{16'h7fff}}, {4{2'b01}});
    run_tile("t3_sat_pos", 2, 1'b1, 0, 0, 1'b0);
    run_tile("t3_wrap", 2, 1'b0, 0, 0, 1'b0);
    fill_const(2, {4{16'h8000}}, {4{2'b11}});
    run_tile("t3_sat_negneg", 2, 1'b1, 0, 0, 1'b0);

    // 4: drain backpressure on row 0
    fill_rand(6);
    run_tile("t4_backpressure", 6, 1'b0, 0, 3, 1'b0);

    // 5: reset mid-stream, then a clean tile with start pulsed in DRAIN
    start  = 1'b1;
    k_len  = KW'(10);
    sat_en = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x_valid = 1'b1;
      x_data  = {4{16'h1234}};
      w_data  = {4{2'b01}};
      @(posedge clock); #1;
    end
    rst     = 1'b1;
    x_valid = 1'b0;
    @(posedge clock); #1;
    check("t5 rst busy", 128'(busy_a), 128'(0));
    check("t5 rst x_ready", 128'(x_ready_a), 128'(0));
    check("t5 rst y_row", y_row_a, 128'(0));
    rst = 1'b0;
    @(posedge clock); #1;
    fill_const(1, {4{16'd7}}, {4{2'b01}});
    run_tile("t5_after_rst", 1, 1'b0, 0, 1, 1'b1);

    // 6: empty tile and reserved weight code
    run_tile("t6_klen0", 0, 1'b0, 0, 0, 1'b0);
    fill_const(3, {4{16'd9}}, {4{2'b10}});
    run_tile("t6_reserved", 3, 1'b1, 0, 0, 1'b0);

    // randomized tiles
    for (int t = 0; t < 6; t++) begin
      int kl;
      kl = $urandom_range(1, 40);
      fill_rand(kl);
      run_tile($sformatf("rand%0d", t), kl, 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
